// File: rtl/spi_slave_regfile.sv
// SPI slave with an 8x8 register file.
// Each frame is 16 bits, MSB first: a command byte {rw, a6..a0} followed by a data byte.
// Registers 0..6 are read/write. Register 7 is a read-only count of completed writes.
// Everything runs in the SCK domain. Reset is synchronous and active-low.
module spi_slave_regfile (
  input  logic       SCK,
  input  logic       reset,
  input  logic       SSB,
  input  logic       MOSI,
  output logic       MISO,
  output logic       wr_valid,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic [7:0] ctrl
);

  typedef enum logic [2:0] {
    WAIT_HI,
    IDLE,
    CMD,
    DATA,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [6:0]  data_q, data_d;
  logic [6:0]  rd_sr_q, rd_sr_d;
  logic [7:0]  regs_q [0:6];
  logic [7:0]  regs_d [0:6];
  logic [7:0]  wcnt_q, wcnt_d;
  logic        miso_q, miso_d;
  logic        wr_valid_q, wr_valid_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;

  logic [7:0]  cmd_full;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_val;
  logic        last_bit;

  // Command and data bytes as they look on the edge that captures their final bit.
  assign cmd_full = {cmd_q[6:0], MOSI};
  assign wr_byte  = {data_q, MOSI};
  assign last_bit = (bit_cnt_q == 3'd7);

  // Read mux for the address in the command being completed. Address 7 returns the write counter.
  always_comb begin
    rd_val = wcnt_q;
    for (int i = 0; i < 7; i++) begin
      if (cmd_full[2:0] == i[2:0]) begin
        rd_val = regs_q[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge SCK) begin
    if (!reset) begin
      state_q <= WAIT_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. SSB high during CMD or DATA aborts the frame back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_HI: if (SSB) state_d = IDLE;
      IDLE:    if (!SSB) state_d = CMD;
      CMD: begin
        if (SSB)           state_d = IDLE;
        else if (last_bit) state_d = DATA;
      end
      DATA: begin
        if (SSB)           state_d = IDLE;
        else if (last_bit) state_d = DONE;
      end
      DONE:    if (SSB) state_d = IDLE;
      default: state_d = WAIT_HI;
    endcase
  end

  // Output and datapath logic: shifting, read serialisation, register writes, and status pulses.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    rd_sr_d     = rd_sr_q;
    regs_d      = regs_q;
    wcnt_d      = wcnt_q;
    miso_d      = 1'b0;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        if (!SSB) begin
          cmd_d     = {7'd0, MOSI};
          bit_cnt_d = 3'd1;
        end
      end

      CMD: begin
        if (SSB) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = 3'd0;
        end else begin
          cmd_d     = cmd_full;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit && cmd_full[7]) begin
            rd_sr_d = rd_val[6:0];
            miso_d  = rd_val[7];
          end
        end
      end

      DATA: begin
        if (SSB) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = 3'd0;
        end else begin
          data_d    = wr_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (cmd_q[7]) begin
            if (!last_bit) begin
              miso_d  = rd_sr_q[6];
              rd_sr_d = {rd_sr_q[5:0], 1'b0};
            end
          end else if (last_bit) begin
            if (cmd_q[2:0] == 3'd7) begin
              frame_err_d = 1'b1;
            end else begin
              for (int i = 0; i < 7; i++) begin
                if (cmd_q[2:0] == i[2:0]) begin
                  regs_d[i] = wr_byte;
                end
              end
              wcnt_d     = wcnt_q + 8'd1;
              wr_valid_d = 1'b1;
              wr_addr_d  = cmd_q[2:0];
              wr_data_d  = wr_byte;
            end
          end
        end
      end

      default: begin
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Datapath registers. Reset clears them all and discards any frame in progress.
  always_ff @(posedge SCK) begin
    if (!reset) begin
      bit_cnt_q   <= 3'd0;
      cmd_q       <= 8'd0;
      data_q      <= 7'd0;
      rd_sr_q     <= 7'd0;
      wcnt_q      <= 8'd0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 3'd0;
      wr_data_q   <= 8'd0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        regs_q[i] <= 8'd0;
      end
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      rd_sr_q     <= rd_sr_d;
      wcnt_q      <= wcnt_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < 7; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign MISO      = miso_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign ctrl      = regs_q[0];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile.
// A register model supplies every expected value. Expected writes and read bytes are queued when
// a frame is driven, then popped when the DUT produces the matching output.
module tb_spi_slave_regfile;

  logic       SCK;
  logic       reset;
  logic       SSB;
  logic       MOSI;
  logic       MISO;
  logic       wr_valid;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] ctrl;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wrExp_t;

  wrExp_t     expWr[$];
  logic [7:0] expRd[$];
  logic [7:0] mregs [0:7];
  int         vectorCount = 0;
  int         missCount   = 0;

  spi_slave_regfile dut (
    .SCK       (SCK),
    .reset     (reset),
    .SSB       (SSB),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .ctrl      (ctrl)
  );

  // Free-running SPI clock.
  initial begin
    SCK = 1'b0;
    forever #5 SCK = ~SCK;
  end

  // Hard time limit, so a stuck DUT still produces a report.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    missCount++;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every wr_valid pulse is popped against the expected-write queue.
  always @(negedge SCK) begin
    if (reset && wr_valid) begin
      if (expWr.size() == 0) begin
        checkOutput("wrSpurious", 32'd1, 32'd0);
      end else begin
        wrExp_t e;
        e = expWr.pop_front();
        checkOutput("wrAddr", {29'd0, wr_addr}, {29'd0, e.addr});
        checkOutput("wrData", {24'd0, wr_data}, {24'd0, e.data});
      end
    end
  end

  // Drive one frame of nbits bits (16 = complete frame), then up to 'extra' ignored bits.
  // SSB is then raised, and the status pulses are checked against the model.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data, input int nbits, input int extra);
    logic [15:0] frame;
    logic [7:0]  rdByte;
    logic [2:0]  addr;
    logic        isRead;
    logic        expWrPulse;
    logic        expErr;
    frame      = {cmd, data};
    isRead     = cmd[7];
    addr       = cmd[2:0];
    rdByte     = 8'd0;
    expWrPulse = 1'b0;
    expErr     = 1'b0;
    if (nbits < 16) begin
      expErr = (nbits > 0);
    end else if (isRead) begin
      expRd.push_back(mregs[addr]);
    end else if (addr == 3'd7) begin
      expErr = 1'b1;
    end else begin
      mregs[addr] = data;
      mregs[7]    = mregs[7] + 8'd1;
      expWr.push_back('{addr: addr, data: data});
      expWrPulse  = 1'b1;
    end

    for (int i = 0; i < nbits; i++) begin
      @(negedge SCK);
      if (i >= 8) begin
        rdByte[15-i] = MISO;
        if (!isRead && i >= 9) checkOutput("misoWrData", {31'd0, MISO}, 32'd0);
      end
      SSB  = 1'b0;
      MOSI = frame[15-i];
    end
    @(negedge SCK);

    if (nbits == 16) begin
      checkOutput("misoDone", {31'd0, MISO}, 32'd0);
      checkOutput("wrValid", {31'd0, wr_valid}, {31'd0, expWrPulse});
      checkOutput("frameErrEnd", {31'd0, frame_err}, {31'd0, expErr});
      if (!isRead && addr == 3'd0) checkOutput("ctrl", {24'd0, ctrl}, {24'd0, mregs[0]});
      if (isRead) begin
        logic [7:0] e;
        if (expRd.size() == 0) begin
          checkOutput("rdQueueEmpty", 32'd1, 32'd0);
        end else begin
          e = expRd.pop_front();
          checkOutput("rdByte", {24'd0, rdByte}, {24'd0, e});
        end
      end
      for (int j = 0; j < extra; j++) begin
        SSB  = 1'b0;
        MOSI = 1'($urandom);
        @(negedge SCK);
        checkOutput("misoIgnored", {31'd0, MISO}, 32'd0);
        checkOutput("wrIgnored", {31'd0, wr_valid}, 32'd0);
      end
    end

    SSB  = 1'b1;
    MOSI = 1'b0;
    @(negedge SCK);
    if (nbits > 0 && nbits < 16) begin
      checkOutput("frameErrAbort", {31'd0, frame_err}, 32'd1);
      checkOutput("wrAbort", {31'd0, wr_valid}, 32'd0);
      @(negedge SCK);
    end
    checkOutput("wrPulseWidth", {31'd0, wr_valid}, 32'd0);
    checkOutput("errPulseWidth", {31'd0, frame_err}, 32'd0);
    #2;
    checkOutput("wrPending", expWr.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] fr;
    $display("[TB] start");
    for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
    reset = 1'b0;
    SSB   = 1'b1;
    MOSI  = 1'b0;
    repeat (3) @(negedge SCK);
    checkOutput("rstMiso", {31'd0, MISO}, 32'd0);
    checkOutput("rstWrValid", {31'd0, wr_valid}, 32'd0);
    checkOutput("rstWrAddr", {29'd0, wr_addr}, 32'd0);
    checkOutput("rstWrData", {24'd0, wr_data}, 32'd0);
    checkOutput("rstFrameErr", {31'd0, frame_err}, 32'd0);
    checkOutput("rstCtrl", {24'd0, ctrl}, 32'd0);
    reset = 1'b1;
    @(negedge SCK);

    // Basic write, then read it back along with the write counter.
    applyStimulus(8'h03, 8'hA5, 16, 0);
    applyStimulus(8'h83, 8'h00, 16, 0);
    applyStimulus(8'h87, 8'h00, 16, 0);
    // A write to register 0 appears on ctrl.
    applyStimulus(8'h00, 8'h5C, 16, 0);
    // Abort inside the data byte, then inside the command byte.
    applyStimulus(8'h02, 8'hFF, 11, 0);
    applyStimulus(8'h82, 8'h00, 16, 0);
    applyStimulus(8'h87, 8'h00, 16, 0);
    applyStimulus(8'h05, 8'h33, 4, 0);
    // A write to read-only register 7 is refused.
    applyStimulus(8'h07, 8'h12, 16, 0);
    applyStimulus(8'h87, 8'h00, 16, 0);
    // The high address bits are ignored.
    applyStimulus(8'h7C, 8'h96, 16, 0);
    applyStimulus(8'hFC, 8'h00, 16, 0);
    applyStimulus(8'hFB, 8'h00, 16, 0);
    // 256 writes to reg 1 wrap the counter. The last write is followed by ignored bits.
    for (int n = 0; n < 256; n++) begin
      applyStimulus(8'h01, 8'(n * 7 + 1), 16, (n == 255) ? 20 : 0);
    end
    applyStimulus(8'h87, 8'h00, 16, 0);
    applyStimulus(8'h81, 8'h00, 16, 0);

    // Reset in the middle of a read while SSB stays low.
    fr = 16'h8300;
    for (int i = 0; i < 12; i++) begin
      @(negedge SCK);
      SSB  = 1'b0;
      MOSI = fr[15-i];
    end
    @(negedge SCK);
    reset = 1'b0;
    repeat (2) @(negedge SCK);
    reset = 1'b1;
    checkOutput("midRstMiso", {31'd0, MISO}, 32'd0);
    checkOutput("midRstCtrl", {24'd0, ctrl}, 32'd0);
    checkOutput("midRstErr", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
    // With SSB still low, this frame must be ignored.
    fr = 16'h0577;
    for (int i = 0; i < 16; i++) begin
      @(negedge SCK);
      MOSI = fr[15-i];
      checkOutput("ignoredMiso", {31'd0, MISO}, 32'd0);
    end
    @(negedge SCK);
    checkOutput("ignoredWr", {31'd0, wr_valid}, 32'd0);
    checkOutput("ignoredErr", {31'd0, frame_err}, 32'd0);
    SSB = 1'b1;
    @(negedge SCK);
    applyStimulus(8'h85, 8'h00, 16, 0);
    applyStimulus(8'h83, 8'h00, 16, 0);
    applyStimulus(8'h80, 8'h00, 16, 0);
    applyStimulus(8'h87, 8'h00, 16, 0);
    applyStimulus(8'h01, 8'h3C, 16, 0);
    applyStimulus(8'h81, 8'h00, 16, 0);

    checkOutput("rdPending", expRd.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
